// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for an in-order pipeline.
// Tracks the destination of the last NUM_STAGES issued instructions and,
// for each decode source, picks the youngest in-flight producer. A load
// that is too young to forward raises a combinational stall.
module hazard_forward_unit #(
    parameter  int NUM_SRC    = 2,
    parameter  int NUM_STAGES = 3,
    parameter  int LOAD_LAT   = 1,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     ID_VALID,
    input  logic [NUM_SRC*5-1:0]     ID_RS,
    input  logic [NUM_SRC-1:0]       ID_RS_USED,
    input  logic [4:0]               ID_RD,
    input  logic                     ID_WEN,
    input  logic                     ID_IS_LOAD,
    input  logic                     HOLD,
    input  logic                     FLUSH,
    output logic                     STALL,
    output logic [NUM_SRC*SEL_W-1:0] FWD_SEL,
    output logic [15:0]              STALL_CNT
);

    // Tracker: index 0 is the instruction in EX, higher indices are older.
    logic [NUM_STAGES-1:0][4:0]  rd_q, rd_d;
    logic [NUM_STAGES-1:0]       wen_q, wen_d;
    logic [NUM_STAGES-1:0]       ld_q, ld_d;
    logic [NUM_SRC*SEL_W-1:0]    sel_q, sel_d;
    logic [15:0]                 cnt_q, cnt_d;

    logic [NUM_SRC*SEL_W-1:0]    next_sel;
    logic                        load_hit;
    logic                        bubble;

    // Per-source youngest-match search; scanning oldest to youngest lets the
    // youngest match overwrite any older one.
    always_comb begin
        next_sel = '0;
        load_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_STAGES - 1; k >= 0; k--) begin
                if (ID_RS_USED[i] && wen_q[k] && (rd_q[k] != 5'd0) &&
                    (rd_q[k] == ID_RS[5*i +: 5])) begin
                    next_sel[SEL_W*i +: SEL_W] = SEL_W'(k + 1);
                    if ((k < LOAD_LAT) && ld_q[k]) begin
                        load_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign STALL  = ID_VALID & ~FLUSH & load_hit;
    assign bubble = FLUSH | STALL;

    // Next tracker / select / counter state for advance, stall, flush and hold.
    always_comb begin
        rd_d  = rd_q;
        wen_d = wen_q;
        ld_d  = ld_q;
        sel_d = sel_q;
        cnt_d = cnt_q;
        if (!HOLD) begin
            for (int k = NUM_STAGES - 1; k > 0; k--) begin
                rd_d[k]  = rd_q[k-1];
                wen_d[k] = wen_q[k-1];
                ld_d[k]  = ld_q[k-1];
            end
            if (bubble) begin
                rd_d[0]  = 5'd0;
                wen_d[0] = 1'b0;
                ld_d[0]  = 1'b0;
                sel_d    = '0;
            end else begin
                rd_d[0]  = ID_RD;
                wen_d[0] = ID_WEN & ID_VALID;
                ld_d[0]  = ID_IS_LOAD & ID_VALID;
                sel_d    = ID_VALID ? next_sel : '0;
            end
            if (STALL && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (FLUSH) begin
            // Frozen pipe: only the squashed decode slot turns into a bubble.
            rd_d[0]  = 5'd0;
            wen_d[0] = 1'b0;
            ld_d[0]  = 1'b0;
            sel_d    = '0;
        end
    end

    // State registers with asynchronous clear to an empty pipeline.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            rd_q  <= '0;
            wen_q <= '0;
            ld_q  <= '0;
            sel_q <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wen_q <= wen_d;
            ld_q  <= ld_d;
            sel_q <= sel_d;
            cnt_q <= cnt_d;
        end
    end

    assign FWD_SEL   = sel_q;
    assign STALL_CNT = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and randomized checks of hazard_forward_unit against a
// history-of-issued-instructions reference model.
module tb_hazard_forward_unit;

    localparam int NSRC = 2;
    localparam int NST  = 3;
    localparam int LLAT = 1;
    localparam int SW   = 2;

    logic              CLK = 1'b0;
    logic              RESETN;
    logic              ID_VALID;
    logic [NSRC*5-1:0] ID_RS;
    logic [NSRC-1:0]   ID_RS_USED;
    logic [4:0]        ID_RD;
    logic              ID_WEN;
    logic              ID_IS_LOAD;
    logic              HOLD;
    logic              FLUSH;
    logic              STALL;
    logic [NSRC*SW-1:0] FWD_SEL;
    logic [15:0]       STALL_CNT;

    int tests = 0;
    int fails = 0;

    // Reference model: what was issued into each in-flight slot.
    logic [4:0]        m_rd  [NST];
    logic              m_wen [NST];
    logic              m_ld  [NST];
    logic [NSRC*SW-1:0] m_sel;
    int                m_cnt;
    logic              last_stall;

    hazard_forward_unit #(.NUM_SRC(NSRC), .NUM_STAGES(NST), .LOAD_LAT(LLAT)) dut (
        .CLK(CLK), .RESETN(RESETN), .ID_VALID(ID_VALID), .ID_RS(ID_RS),
        .ID_RS_USED(ID_RS_USED), .ID_RD(ID_RD), .ID_WEN(ID_WEN),
        .ID_IS_LOAD(ID_IS_LOAD), .HOLD(HOLD), .FLUSH(FLUSH), .STALL(STALL),
        .FWD_SEL(FWD_SEL), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NST; k++) begin
            m_rd[k] = 5'd0; m_wen[k] = 1'b0; m_ld[k] = 1'b0;
        end
        m_sel = '0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESETN = 1'b0;
        #1;
        check("rst_stall", {31'd0, STALL}, 32'd0);
        check("rst_fwd", {28'd0, FWD_SEL}, 32'd0);
        check("rst_cnt", {16'd0, STALL_CNT}, 32'd0);
        model_clear();
        @(negedge CLK);
        RESETN = 1'b1;
    endtask

    task automatic do_cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [1:0] used, input logic [4:0] rd, input logic wen,
                            input logic ld, input logic hold, input logic flush);
        logic [NSRC*SW-1:0] nsel;
        logic               est;
        logic [4:0]         src;
        @(negedge CLK);
        ID_VALID = v; ID_RS = {rs2, rs1}; ID_RS_USED = used; ID_RD = rd;
        ID_WEN = wen; ID_IS_LOAD = ld; HOLD = hold; FLUSH = flush;
        #1;
        // Youngest producer of each source wins; a load too young to forward stalls.
        nsel = '0;
        est  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src = (i == 0) ? rs1 : rs2;
            for (int k = 0; k < NST; k++) begin
                if (used[i] && m_wen[k] && m_rd[k] != 5'd0 && m_rd[k] == src) begin
                    nsel[SW*i +: SW] = SW'(k + 1);
                    if (k < LLAT && m_ld[k] && v && !flush) est = 1'b1;
                    break;
                end
            end
        end
        last_stall = STALL;
        check("stall", {31'd0, STALL}, {31'd0, est});
        @(posedge CLK);
        #1;
        if (!hold) begin
            for (int k = NST - 1; k > 0; k--) begin
                m_rd[k] = m_rd[k-1]; m_wen[k] = m_wen[k-1]; m_ld[k] = m_ld[k-1];
            end
            if (flush || est) begin
                m_rd[0] = 5'd0; m_wen[0] = 1'b0; m_ld[0] = 1'b0; m_sel = '0;
            end else begin
                m_rd[0] = rd; m_wen[0] = wen & v; m_ld[0] = ld & v;
                m_sel = v ? nsel : '0;
            end
            if (est && m_cnt < 65535) m_cnt++;
        end else if (flush) begin
            m_rd[0] = 5'd0; m_wen[0] = 1'b0; m_ld[0] = 1'b0; m_sel = '0;
        end
        check("fwd_sel", {28'd0, FWD_SEL}, {28'd0, m_sel});
        check("stall_cnt", {16'd0, STALL_CNT}, m_cnt);
    endtask

    task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used);
        do_cycle(1'b1, rs1, rs2, used, rd, wen, ld, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) do_cycle(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RESETN = 1'b0; ID_VALID = 1'b0; ID_RS = '0; ID_RS_USED = '0; ID_RD = '0;
        ID_WEN = 1'b0; ID_IS_LOAD = 1'b0; HOLD = 1'b0; FLUSH = 1'b0;
        model_clear();
        #2;
        check("por_stall", {31'd0, STALL}, 32'd0);
        check("por_fwd", {28'd0, FWD_SEL}, 32'd0);
        check("por_cnt", {16'd0, STALL_CNT}, 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;

        // ALU producer followed by dependent consumer on rs1.
        issue(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
        issue(5'd9, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01);
        check("alu_fwd", {28'd0, FWD_SEL}, 32'h1);
        check("alu_nostall", {31'd0, last_stall}, 32'd0);

        // Two writers of x7: the younger one must be selected.
        idle(3);
        issue(5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
        issue(5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
        issue(5'd10, 1'b1, 1'b0, 5'd0, 5'd7, 2'b10);
        check("youngest_fwd", {28'd0, FWD_SEL}, 32'h4);

        // Load-use: one stall cycle with a bubble, then forward from MEM.
        idle(3);
        issue(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
        issue(5'd11, 1'b1, 1'b0, 5'd8, 5'd0, 2'b01);
        check("lu_stall", {31'd0, last_stall}, 32'd1);
        check("lu_bubble", {28'd0, FWD_SEL}, 32'd0);
        issue(5'd11, 1'b1, 1'b0, 5'd8, 5'd0, 2'b01);
        check("lu_resolved_stall", {31'd0, last_stall}, 32'd0);
        check("lu_fwd", {28'd0, FWD_SEL}, 32'h2);
        check("lu_cnt", {16'd0, STALL_CNT}, 32'd1);

        // x0 never forwards; unused sources never forward or stall.
        idle(3);
        issue(5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
        issue(5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11);
        check("x0_fwd", {28'd0, FWD_SEL}, 32'd0);
        check("x0_stall", {31'd0, last_stall}, 32'd0);
        issue(5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
        issue(5'd12, 1'b1, 1'b0, 5'd3, 5'd3, 2'b00);
        check("unused_fwd", {28'd0, FWD_SEL}, 32'd0);
        check("unused_stall", {31'd0, last_stall}, 32'd0);

        // Load-use under a 3-cycle hold: stall stays up, nothing moves.
        do_reset();
        issue(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
        for (int j = 0; j < 3; j++) begin
            do_cycle(1'b1, 5'd8, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0);
            check("hold_stall", {31'd0, last_stall}, 32'd1);
            check("hold_cnt", {16'd0, STALL_CNT}, 32'd0);
        end
        issue(5'd13, 1'b1, 1'b0, 5'd8, 5'd0, 2'b01);
        check("hold_lu_cnt", {16'd0, STALL_CNT}, 32'd1);
        issue(5'd13, 1'b1, 1'b0, 5'd8, 5'd0, 2'b01);
        check("hold_lu_fwd", {28'd0, FWD_SEL}, 32'h2);

        // Flushed producer is never a forwarding source.
        idle(3);
        do_cycle(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(5'd14, 1'b1, 1'b0, 5'd4, 5'd4, 2'b11);
        check("flush_fwd", {28'd0, FWD_SEL}, 32'd0);
        // Flush while frozen squashes only the EX slot.
        idle(3);
        issue(5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
        issue(5'd15, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
        do_cycle(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(5'd16, 1'b1, 1'b0, 5'd6, 5'd15, 2'b11);
        check("hold_flush_fwd", {28'd0, FWD_SEL}, 32'h2);

        // Reset in the middle of a load-use stall.
        issue(5'd8, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00);
        @(negedge CLK);
        ID_VALID = 1'b1; ID_RS = {5'd0, 5'd8}; ID_RS_USED = 2'b01; HOLD = 1'b1; FLUSH = 1'b0;
        #1;
        check("pre_rst_stall", {31'd0, STALL}, 32'd1);
        do_reset();

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            do_cycle(($urandom_range(0, 9) != 0),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter NUM_SRC, 2: number of source operands per instruction; legal range 1-3.
REQ-002 Parameter NUM_STAGES, 3: number of tracked in-flight producer stages (EX, MEM, WB); legal range 2-6.
REQ-003 Parameter LOAD_LAT, 1: number of youngest tracked stages in which load data is not yet forwardable; legal range 1 to NUM_STAGES-1.
REQ-004 Local parameter SEL_W SHALL equal clog2(NUM_STAGES+1).
REQ-005 Port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port RESETN, input, 1: asynchronous, active-low reset.
REQ-007 Port ID_VALID, input, 1: the decode-stage instruction is valid.
REQ-008 Port ID_RS, input, NUM_SRC*5: packed decode source addresses; source i occupies bits [5i+4:5i].
REQ-009 Port ID_RS_USED, input, NUM_SRC: source i is actually read.
REQ-010 Port ID_RD, input, 5: decode destination address.
REQ-011 Port ID_WEN, input, 1: decode instruction writes ID_RD.
REQ-012 Port ID_IS_LOAD, input, 1: decode instruction is a load.
REQ-013 Port HOLD, input, 1: global pipeline freeze, e.g. a memory wait.
REQ-014 Port FLUSH, input, 1: squashes the decode instruction (branch taken).
REQ-015 Port STALL, output, 1: combinational load-use stall request to the fetch/decode stages.
REQ-016 Port FWD_SEL, output, NUM_SRC*SEL_W: registered per-source forward select for the instruction currently in EX.
REQ-017 Port STALL_CNT, output, 16: saturating count of stall cycles.

Function
REQ-018 The unit SHALL hold a tracker of NUM_STAGES entries {rd[4:0], wen, is_load}; entry 0 is the instruction in EX, and entry k is k stages older.
REQ-019 An entry SHALL match source i only if ID_RS_USED[i]=1, entry wen=1, entry rd!=0 and entry rd equals source address i.
REQ-020 next_sel[i] SHALL be k+1, where k is the lowest-index (youngest) matching entry, or 0 if no entry matches.
REQ-021 STALL SHALL be 1 when ID_VALID=1, FLUSH=0 and any source matches an entry with index < LOAD_LAT and is_load=1; otherwise STALL SHALL be 0.
REQ-022 Advance cycle (HOLD=0, STALL=0, FLUSH=0): entries SHALL shift k to k+1, and the oldest entry SHALL be discarded.
REQ-023 On an advance cycle, entry 0 SHALL be loaded with {ID_RD, ID_WEN&ID_VALID, ID_IS_LOAD&ID_VALID}, and FWD_SEL SHALL be loaded with next_sel, or with 0 when ID_VALID=0.
REQ-024 Stall cycle (HOLD=0, STALL=1): entries SHALL shift, entry 0 SHALL receive a bubble (wen=0, is_load=0), and FWD_SEL SHALL be loaded with 0.
REQ-025 On a stall cycle, STALL_CNT SHALL increment by 1, saturating at 16'hFFFF.
REQ-026 FLUSH=1 with HOLD=0: entries SHALL shift, entry 0 SHALL receive a bubble, and FWD_SEL SHALL be loaded with 0.
REQ-027 FLUSH=1 with HOLD=1: entry 0 SHALL be cleared to a bubble and FWD_SEL SHALL be cleared to 0; entries 1 and above SHALL hold.
REQ-028 HOLD=1 with FLUSH=0: all entries, FWD_SEL and STALL_CNT SHALL hold; STALL SHALL still be driven combinationally.
REQ-029 Latency: a dependence that is resolved on the decode cycle SHALL appear on FWD_SEL on the following cycle, aligned with the instruction's EX cycle.
REQ-030 Encoding: FWD_SEL value v>0 selects the result of the stage (v-1) positions beyond EX at the time the consumer executes; v=0 selects the register file.

Reset
REQ-031 While RESETN=0, all tracker entries SHALL be bubbles, and FWD_SEL, STALL_CNT and STALL SHALL be 0, independent of CLK.
REQ-032 After RESETN deasserts, normal operation SHALL resume on the first rising CLK edge; no warm-up cycles are required.
REQ-033 Asserting RESETN mid-stall or mid-hold SHALL discard all in-flight state.

Verification (defaults NUM_SRC=2, NUM_STAGES=3, LOAD_LAT=1)
REQ-034 Issue an ALU op writing x5, then a consumer with rs1=x5 -> the cycle after the consumer issues, FWD_SEL[1:0]=1, FWD_SEL[3:2]=0 and STALL=0.
REQ-035 Issue two back-to-back writers of x7, then a consumer with rs2=x7 -> FWD_SEL[3:2]=1 (youngest writer wins), not 2.
REQ-036 Issue a load writing x8, then a consumer with rs1=x8 -> STALL=1 for exactly one cycle and FWD_SEL=0 on the following (bubble) cycle; the next cycle has FWD_SEL[1:0]=2 and STALL_CNT=1.
REQ-037 Issue a writer with rd=x0, then a consumer with rs1=x0 and rs2=x0 -> FWD_SEL=0 and STALL=0; a consumer with ID_RS_USED=0 and matching rd also gives no forward and no stall.
REQ-038 Drive the load-use case of REQ-036 with HOLD=1 for 3 cycles -> STALL stays 1, STALL_CNT stays 0 and the tracker is frozen; after HOLD falls, behaviour matches REQ-036.
REQ-039 Assert FLUSH on a producer's decode cycle, then issue a consumer of its rd -> FWD_SEL=0; assert RESETN=0 mid-sequence -> all outputs are 0 immediately.
